// File: rtl/risc8_io_pkg.sv
// Shared definitions for the risc8 IO bus: field widths, arbiter FSM
// encoding and the data returned on a read timeout.
package risc8_io_pkg;

   localparam int IO_ADDR_W = 7;
   localparam int IO_DATA_W = 8;
   localparam logic [IO_DATA_W-1:0] IO_TIMEOUT_DATA = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } io_state_e;

endpackage

// File: rtl/risc8_io_rr_arb.sv
// Two-requester round-robin: on contention the master not granted last wins.
// The pointer only moves once a transfer has completed.
module risc8_io_rr_arb (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   input  logic       upd_i,
   input  logic       upd_id_i,
   output logic [1:0] gnt_o
);

   logic last_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q <= 1'b1;
      end else if (upd_i) begin
         last_q <= upd_id_i;
      end
   end

   always_comb begin
      unique case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/risc8_io_arbiter.sv
// Shares the risc8 IO bus between the CPU (m0) and a secondary master (m1):
// one strobe per grant, response collection with timeout/conflict detection.
module risc8_io_arbiter
   import risc8_io_pkg::*;
#(
   parameter int N_DEV   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     m0_req,
   input  logic                     m0_we,
   input  logic [IO_ADDR_W-1:0]     m0_addr,
   input  logic [IO_DATA_W-1:0]     m0_wdata,
   output logic                     m0_ack,
   output logic [IO_DATA_W-1:0]     m0_rdata,
   output logic                     m0_err,
   input  logic                     m1_req,
   input  logic                     m1_we,
   input  logic [IO_ADDR_W-1:0]     m1_addr,
   input  logic [IO_DATA_W-1:0]     m1_wdata,
   output logic                     m1_ack,
   output logic [IO_DATA_W-1:0]     m1_rdata,
   output logic                     m1_err,
   output logic                     io_ren,
   output logic                     io_wen,
   output logic [IO_ADDR_W-1:0]     io_addr,
   output logic [IO_DATA_W-1:0]     io_wdata,
   input  logic [N_DEV-1:0]         dev_valid,
   input  logic [8*N_DEV-1:0]       dev_rdata,
   output logic                     busy,
   output logic [7:0]               err_count
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   io_state_e            state_q, state_d;
   logic                 win_q, win_d;
   logic                 we_q, we_d;
   logic [IO_ADDR_W-1:0] addr_q, addr_d;
   logic [IO_DATA_W-1:0] wdata_q, wdata_d;
   logic                 err_q, err_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [7:0]           err_count_q, err_count_d;
   logic                 io_ren_q, io_ren_d, io_wen_q, io_wen_d;
   logic                 busy_q, busy_d;
   logic                 m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
   logic                 m0_err_q, m0_err_d, m1_err_q, m1_err_d;
   logic [IO_DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

   logic [1:0]           gnt;
   logic [IO_DATA_W-1:0] cap_rdata, or_rdata;
   logic                 cap_err;
   int                   n_valid;

   risc8_io_rr_arb u_arb (
      .clk      (clk),
      .reset    (reset),
      .req_i    ({m1_req, m0_req}),
      .upd_i    (state_q == RESP),
      .upd_id_i (win_q),
      .gnt_o    (gnt)
   );

   always_comb begin
      n_valid  = 0;
      or_rdata = '0;
      for (int i = 0; i < N_DEV; i++) begin
         if (dev_valid[i]) begin
            n_valid++;
            or_rdata |= dev_rdata[8*i +: 8];
         end
      end
   end

   // NOTE: every variable gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      err_count_d = err_count_q;
      io_ren_d    = 1'b0;
      io_wen_d    = 1'b0;
      cap_rdata   = '0;
      cap_err     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (gnt != 2'b00) begin
               win_d    = gnt[1];
               we_d     = gnt[1] ? m1_we    : m0_we;
               addr_d   = gnt[1] ? m1_addr  : m0_addr;
               wdata_d  = gnt[1] ? m1_wdata : m0_wdata;
               io_wen_d = we_d;
               io_ren_d = !we_d;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            if (we_q) begin
               err_d   = 1'b0;
               state_d = RESP;
            end else begin
               cnt_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (n_valid != 0) begin
               cap_rdata = or_rdata;
               cap_err   = (n_valid > 1);
               err_d     = cap_err;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  cap_rdata = IO_TIMEOUT_DATA;
                  cap_err   = 1'b1;
                  err_d     = 1'b1;
                  state_d   = RESP;
               end
            end
         end
         RESP: begin
            if (err_q && err_count_q != 8'hFF) begin
               err_count_d = err_count_q + 8'd1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // The acknowledge and its payload are launched on the edge that enters RESP.
      m0_ack_d   = (state_d == RESP) && !win_q;
      m1_ack_d   = (state_d == RESP) &&  win_q;
      m0_rdata_d = m0_ack_d ? cap_rdata : '0;
      m1_rdata_d = m1_ack_d ? cap_rdata : '0;
      m0_err_d   = m0_ack_d && cap_err;
      m1_err_d   = m1_ack_d && cap_err;
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         win_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         err_count_q <= '0;
         io_ren_q    <= 1'b0;
         io_wen_q    <= 1'b0;
         busy_q      <= 1'b0;
         m0_ack_q    <= 1'b0;
         m1_ack_q    <= 1'b0;
         m0_err_q    <= 1'b0;
         m1_err_q    <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         err_count_q <= err_count_d;
         io_ren_q    <= io_ren_d;
         io_wen_q    <= io_wen_d;
         busy_q      <= busy_d;
         m0_ack_q    <= m0_ack_d;
         m1_ack_q    <= m1_ack_d;
         m0_err_q    <= m0_err_d;
         m1_err_q    <= m1_err_d;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
      end
   end

   assign m0_ack    = m0_ack_q;
   assign m1_ack    = m1_ack_q;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;
   assign m0_err    = m0_err_q;
   assign m1_err    = m1_err_q;
   assign io_ren    = io_ren_q;
   assign io_wen    = io_wen_q;
   assign io_addr   = addr_q;
   assign io_wdata  = wdata_q;
   assign busy      = busy_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_risc8_io_arbiter.sv
// Directed bench for risc8_io_arbiter: write/read latency, round-robin,
// timeout, conflict saturation and reset mid-transfer.
module tb_risc8_io_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [6:0]  m0_addr, m1_addr;
   logic [7:0]  m0_wdata, m1_wdata;
   logic        m0_ack, m1_ack, m0_err, m1_err;
   logic [7:0]  m0_rdata, m1_rdata;
   logic        io_ren, io_wen;
   logic [6:0]  io_addr;
   logic [7:0]  io_wdata;
   logic [3:0]  dev_valid;
   logic [31:0] dev_rdata;
   logic        busy;
   logic [7:0]  err_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   risc8_io_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_ack    (m0_ack),
      .m0_rdata  (m0_rdata),
      .m0_err    (m0_err),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_ack    (m1_ack),
      .m1_rdata  (m1_rdata),
      .m1_err    (m1_err),
      .io_ren    (io_ren),
      .io_wen    (io_wen),
      .io_addr   (io_addr),
      .io_wdata  (io_wdata),
      .dev_valid (dev_valid),
      .dev_rdata (dev_rdata),
      .busy      (busy),
      .err_count (err_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit m, input bit val);
      if (m) m1_req = val;
      else   m0_req = val;
   endtask

   // Read with the responding slot(s) asserting valid in the first WAIT cycle.
   task automatic read_xfer(input bit m, input logic [6:0] a, input logic [3:0] v,
                            input logic [31:0] d, input logic [7:0] exp_d,
                            input bit exp_e, input string tag);
      if (m) begin m1_we = 1'b0; m1_addr = a; end
      else   begin m0_we = 1'b0; m0_addr = a; end
      set_req(m, 1'b1);
      tick();
      check({tag, "_ren"}, io_ren, 1);
      check({tag, "_addr"}, io_addr, a);
      tick();
      dev_valid = v;
      dev_rdata = d;
      check({tag, "_noack_t2"}, {m1_ack, m0_ack}, 0);
      tick();
      check({tag, "_ack"}, {m1_ack, m0_ack}, m ? 2'b10 : 2'b01);
      check({tag, "_rdata"}, m ? m1_rdata : m0_rdata, exp_d);
      check({tag, "_err"}, m ? m1_err : m0_err, exp_e);
      check({tag, "_other_rdata"}, m ? m0_rdata : m1_rdata, 0);
      dev_valid = '0;
      dev_rdata = '0;
      set_req(m, 1'b0);
      tick();
   endtask

   initial begin
      reset = 1'b0;
      {m0_req, m0_we, m0_addr, m0_wdata} = '0;
      {m1_req, m1_we, m1_addr, m1_wdata} = '0;
      dev_valid = '0;
      dev_rdata = '0;
      repeat (2) tick();
      check("rst_ack", {m1_ack, m0_ack}, 0);
      check("rst_strobes", {io_ren, io_wen}, 0);
      check("rst_busy", busy, 0);
      check("rst_err_count", err_count, 0);
      check("rst_io_addr", io_addr, 0);
      reset = 1'b1;
      tick();

      // m0 write 0x38 <- 0xA5
      m0_we = 1'b1; m0_addr = 7'h38; m0_wdata = 8'hA5; m0_req = 1'b1;
      tick();
      check("wr_wen", io_wen, 1);
      check("wr_ren", io_ren, 0);
      check("wr_addr", io_addr, 7'h38);
      check("wr_wdata", io_wdata, 8'hA5);
      check("wr_busy", busy, 1);
      check("wr_noack_t1", m0_ack, 0);
      tick();
      check("wr_ack", {m1_ack, m0_ack}, 2'b01);
      check("wr_err", m0_err, 0);
      check("wr_rdata", m0_rdata, 0);
      check("wr_wen_drop", io_wen, 0);
      m0_req = 1'b0;
      tick();
      check("wr_ack_pulse", m0_ack, 0);
      check("wr_idle", busy, 0);

      // m1 read 0x4F, timer in slot 2 returns 0x57
      read_xfer(1'b1, 7'h4F, 4'b0100, 32'h0057_0000, 8'h57, 1'b0, "rd_m1");
      check("rd_err_count", err_count, 0);

      // Contention: last grant was m1, so m0 wins first and grants alternate
      m0_we = 1'b1; m0_addr = 7'h01; m0_wdata = 8'h11;
      m1_we = 1'b1; m1_addr = 7'h02; m1_wdata = 8'h22;
      m0_req = 1'b1; m1_req = 1'b1;
      for (int r = 0; r < 4; r++) begin
         automatic bit exp_m = r[0];
         tick();
         check("rr_addr", io_addr, exp_m ? 7'h02 : 7'h01);
         tick();
         check("rr_ack", {m1_ack, m0_ack}, exp_m ? 2'b10 : 2'b01);
         set_req(exp_m, 1'b0);
         tick();
         check("rr_idle", busy, 0);
         set_req(exp_m, 1'b1);
      end
      m0_req = 1'b0; m1_req = 1'b0;
      tick();
      check("rr_done_idle", busy, 0);

      // Unmapped read: no valid, ack at T17 with 0xFF/err
      m0_we = 1'b0; m0_addr = 7'h10; m0_req = 1'b1;
      tick();
      check("to_ren", io_ren, 1);
      for (int t = 2; t <= 16; t++) begin
         tick();
         check("to_noack", m0_ack, 0);
      end
      tick();
      check("to_ack", m0_ack, 1);
      check("to_rdata", m0_rdata, 8'hFF);
      check("to_err", m0_err, 1);
      m0_req = 1'b0;
      tick();
      check("to_err_count", err_count, 1);

      // Conflicts: slots 0 and 1 answer together; counter saturates at 0xFF
      for (int k = 1; k <= 300; k++) begin
         read_xfer(1'b1, 7'h30, 4'b0011, 32'h0000_300F, 8'h3F, 1'b1, "cf");
         check("cf_err_count", err_count, (k + 1 > 255) ? 255 : k + 1);
      end

      // Reset during WAIT aborts the read without an ack
      m0_we = 1'b0; m0_addr = 7'h20; m0_req = 1'b1;
      tick();
      tick();
      tick();
      check("ab_busy_wait", busy, 1);
      reset = 1'b0;
      #1;
      check("ab_busy", busy, 0);
      check("ab_err_count", err_count, 0);
      check("ab_io_addr", io_addr, 0);
      check("ab_ack", {m1_ack, m0_ack}, 0);
      m0_req = 1'b0;
      tick();
      reset = 1'b1;
      for (int t = 0; t < 4; t++) begin
         tick();
         check("ab_no_ack", {m1_ack, m0_ack, busy}, 0);
      end
      read_xfer(1'b1, 7'h4F, 4'b0100, 32'h0066_0000, 8'h66, 1'b0, "post_rst");
      check("post_rst_err_count", err_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/risc8_io_arbiter.md
# risc8_io_arbiter

Shares the single risc8 IO bus (7-bit address, 8-bit data, `ren`/`wen` strobes, per-device registered `valid`/`rdata` responses) between two masters: the CPU core (m0) and a secondary master such as a DMA or debug port (m1). Each accepted request becomes one bus strobe. The block then collects the peripheral response, detects read timeouts and response conflicts, and returns a one-cycle acknowledge to the winning master. It sits between the masters and the UART, timer and GPIO peripherals. It replaces the ad-hoc OR of peripheral outputs.

## Interface
Parameters:
- `N_DEV`, default 4: number of peripheral response slots.
- `TIMEOUT`, default 15: WAIT cycles allowed before a read is failed.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset (asserted at 0).
- `m0_req`, `m1_req`  in  1: request. Held with the command stable until ack.
- `m0_we`, `m1_we`  in  1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  7: IO address.
- `m0_wdata`, `m1_wdata`  in  8: write data.
- `m0_ack`, `m1_ack`  out  1: one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  8: read data. Valid while the matching ack is high.
- `m0_err`, `m1_err`  out  1: error flag. Valid while the matching ack is high.
- `io_ren`, `io_wen`  out  1: one-cycle bus strobes.
- `io_addr`  out  7: latched address.
- `io_wdata`  out  8: latched write data.
- `dev_valid`  in  N_DEV: per-peripheral response valid.
- `dev_rdata`  in  8*N_DEV: per-peripheral read data. Slot i occupies bits [8i+7:8i].
- `busy`  out  1: high whenever the state is not IDLE.
- `err_count`  out  8: saturating count of errored transactions.

## Operation
- State machine: IDLE → ISSUE → (WAIT →) RESP → IDLE. All outputs are registered.
- IDLE:
  - If any `req` is high, pick a winner and latch its `we`/`addr`/`wdata` and the winner id, then go to ISSUE.
  - If only one master requests, it wins.
  - If both request, the master that was not granted last wins (2-way round-robin). The `last` pointer resets to m1, so m0 wins the first contention.
- ISSUE:
  - Exactly one of `io_ren`/`io_wen` is high for this cycle.
  - A write goes to RESP with `err=0`, `rdata=0`.
  - A read clears the timeout counter and goes to WAIT.
- WAIT: each cycle, count the set bits of `dev_valid`.
  - Exactly one set: capture that slot's rdata with `err=0`, go to RESP.
  - Two or more set: capture the bitwise OR of the valid slots' rdata with `err=1` (conflict), go to RESP.
  - None set: increment the counter. When the counter reaches TIMEOUT, set `rdata=8'hFF`, `err=1`, go to RESP.
- RESP:
  - Pulse only the winner's `ack` with the captured `rdata`/`err`. The other master's outputs stay 0.
  - Update `last` to the winner. Increment `err_count` if `err` is set; it saturates at 8'hFF.
  - Go to IDLE.
- `dev_valid` outside WAIT is ignored.
- A request from the losing master stays pending and is served next. Masters must drop `req` in the cycle after `ack`.
- Reset assertion at any point: asynchronously return to IDLE and zero all outputs, `err_count` and the latched command. No `ack` is issued for the aborted transfer.

## Timing
- Reset values: all `ack`/`err`/`rdata`, `io_ren`/`io_wen`/`io_addr`/`io_wdata`, `busy` and `err_count` are 0; `last` = m1.
- Write latency: `req` sampled at T0; `io_wen` high at T1; `ack` high at T2.
- Read latency with a peripheral answering next cycle: `io_ren` high at T1; `valid` high at T2; `ack` high at T3.
- Read timeout: `ack` at T2+TIMEOUT, i.e. T17 with the default.
- Back-to-back transfers: the next grant is sampled in the IDLE cycle after RESP, so there is at least one idle bus cycle between strobes.
- Timeout counter width is $clog2(TIMEOUT+1). The counter never wraps.

## Structure
- Shared package `risc8_io_pkg`: state encoding (IDLE/ISSUE/WAIT/RESP), `IO_ADDR_W=7`, `IO_DATA_W=8`, `IO_TIMEOUT_DATA=8'hFF`.
- Sub-module `risc8_io_rr_arb`: 2-requester round-robin with the `last` pointer. It takes `req[1:0]` and produces a one-hot grant. The pointer is updated only on RESP.

## Test plan
- m0 writes addr 0x38, data 0xA5; the GPIO model latches it → `io_wen` high at T1 with addr 0x38 and data 0xA5; `m0_ack=1`, `err=0` at T2.
- m1 reads addr 0x4F; the timer model returns 0x57 at T2 → `m1_ack` at T3 with `rdata=0x57`, `err=0`; `m0_ack` stays 0.
- m0 and m1 request in the same cycle, repeated 4 times → grants alternate m0, m1, m0, m1; no request is lost.
- Read of an unmapped addr 0x10 with no `valid` → `ack` at T17 with `rdata=0xFF`, `err=1`, `err_count=1`.
- Two slots assert `valid` with 0x0F and 0x30 → `rdata=0x3F`, `err=1`; after 300 such conflicts `err_count` holds at 0xFF.
- Reset driven low during WAIT → outputs are 0 immediately; no `ack` follows; after release, a fresh m1 read completes normally.
